// File: rtl/clint_arb.sv
// Core-local interrupt/exception arbiter: prioritised, maskable IRQs plus sync
// exceptions and mret, sequencing trap CSR writes. `CLINT_MTVAL_EN adds an mtval write.
module clint_arb #(
  parameter int NUM_IRQ        = 8,
  parameter int IRQ_CAUSE_BASE = 16,
  parameter int XLEN           = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_mask_i,
  input  logic               inst_ecall_i,
  input  logic               inst_ebreak_i,
  input  logic               inst_mret_i,
  input  logic               misalign_i,
  input  logic [XLEN-1:0]    inst_addr_i,
  input  logic [XLEN-1:0]    misalign_addr_i,
  input  logic [XLEN-1:0]    csr_mtvec,
  input  logic [XLEN-1:0]    csr_mepc,
  input  logic [XLEN-1:0]    csr_mstatus,
  output logic               we_o,
  output logic [XLEN-1:0]    waddr_o,
  output logic [XLEN-1:0]    data_o,
  output logic               stall_flag_o,
  output logic               int_assert_o,
  output logic [XLEN-1:0]    int_addr_o,
  output logic [NUM_IRQ-1:0] irq_ack_o
);
  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam logic [XLEN-1:0] ADDR_MSTATUS = XLEN'(12'h300);
  localparam logic [XLEN-1:0] ADDR_MEPC    = XLEN'(12'h341);
  localparam logic [XLEN-1:0] ADDR_MCAUSE  = XLEN'(12'h342);

  typedef enum logic [2:0] {S_IDLE, S_MEPC, S_MCAUSE, S_MTVAL, S_MSTATUS, S_MRET} state_e;

  state_e             state_q, state_d;
  logic [XLEN-1:0]    pc_q, cause_q;
  logic [IDX_W-1:0]   idx_q;
  logic               async_q;
  logic [NUM_IRQ-1:0] pending;
  logic [IDX_W-1:0]   irq_idx;
  logic               async_evt, trap_evt, detect_en, event_detect, misalign_evt;
  logic [XLEN-1:0]    cause_sel, mtvec_base, trap_target, mstatus_trap, mstatus_mret;
  logic               we_d, int_assert_d;
  logic [XLEN-1:0]    waddr_d, data_d, int_addr_d;
  logic [NUM_IRQ-1:0] irq_ack_d;

`ifdef CLINT_MTVAL_EN
  localparam logic [XLEN-1:0] ADDR_MTVAL = XLEN'(12'h343);
  logic [XLEN-1:0] mtval_q;
`else
  logic unused_misalign_addr;
  assign unused_misalign_addr = ^misalign_addr_i;
`endif

  // NOTE: every variable gets a default at the top of an always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    pending = irq_i & irq_mask_i;
    irq_idx = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (pending[k]) irq_idx = IDX_W'(k);
    end
    async_evt    = (|pending) & csr_mstatus[3];
    misalign_evt = misalign_i & ~async_evt & ~inst_ebreak_i & ~inst_ecall_i;
    trap_evt     = async_evt | inst_ebreak_i | inst_ecall_i | misalign_i;
    // The redirect cycle is still part of the sequence: the CSR file and ex have not caught up yet.
    detect_en    = (state_q == S_IDLE) & ~int_assert_o;
    event_detect = detect_en & (trap_evt | inst_mret_i);
    if (async_evt)          cause_sel = {1'b1, (XLEN-1)'(IRQ_CAUSE_BASE) + (XLEN-1)'(irq_idx)};
    else if (inst_ebreak_i) cause_sel = XLEN'(3);
    else if (inst_ecall_i)  cause_sel = XLEN'(11);
    else                    cause_sel = XLEN'(4);
  end

  always_comb begin
    mtvec_base   = {csr_mtvec[XLEN-1:2], 2'b00};
    trap_target  = mtvec_base;
    if (async_q && csr_mtvec[1:0] == 2'b01) trap_target = mtvec_base + XLEN'({cause_q[7:0], 2'b00});
    mstatus_trap    = csr_mstatus;
    mstatus_trap[7] = csr_mstatus[3];
    mstatus_trap[3] = 1'b0;
    mstatus_mret    = csr_mstatus;
    mstatus_mret[3] = csr_mstatus[7];
    mstatus_mret[7] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (detect_en && trap_evt)         state_d = S_MEPC;
        else if (detect_en && inst_mret_i) state_d = S_MRET;
      end
      S_MEPC:    state_d = S_MCAUSE;
`ifdef CLINT_MTVAL_EN
      S_MCAUSE:  state_d = S_MTVAL;
      S_MTVAL:   state_d = S_MSTATUS;
`else
      S_MCAUSE:  state_d = S_MSTATUS;
`endif
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    we_d         = 1'b0;
    waddr_d      = '0;
    data_d       = '0;
    int_assert_d = 1'b0;
    int_addr_d   = '0;
    irq_ack_d    = '0;
    case (state_q)
      S_MEPC:   begin we_d = 1'b1; waddr_d = ADDR_MEPC;   data_d = pc_q;    end
      S_MCAUSE: begin we_d = 1'b1; waddr_d = ADDR_MCAUSE; data_d = cause_q; end
`ifdef CLINT_MTVAL_EN
      S_MTVAL:  begin we_d = 1'b1; waddr_d = ADDR_MTVAL;  data_d = mtval_q; end
`endif
      S_MSTATUS: begin
        we_d         = 1'b1;
        waddr_d      = ADDR_MSTATUS;
        data_d       = mstatus_trap;
        int_assert_d = 1'b1;
        int_addr_d   = trap_target;
        if (async_q) irq_ack_d = NUM_IRQ'(1) << idx_q;
      end
      S_MRET: begin
        we_d         = 1'b1;
        waddr_d      = ADDR_MSTATUS;
        data_d       = mstatus_mret;
        int_assert_d = 1'b1;
        int_addr_d   = csr_mepc;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      cause_q      <= '0;
      idx_q        <= '0;
      async_q      <= 1'b0;
      we_o         <= 1'b0;
      waddr_o      <= '0;
      data_o       <= '0;
      int_assert_o <= 1'b0;
      int_addr_o   <= '0;
      irq_ack_o    <= '0;
    end else begin
      state_q      <= state_d;
      we_o         <= we_d;
      waddr_o      <= waddr_d;
      data_o       <= data_d;
      int_assert_o <= int_assert_d;
      int_addr_o   <= int_addr_d;
      irq_ack_o    <= irq_ack_d;
      if (detect_en && trap_evt) begin
        pc_q    <= inst_addr_i;
        cause_q <= cause_sel;
        idx_q   <= irq_idx;
        async_q <= async_evt;
      end
    end
  end

`ifdef CLINT_MTVAL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     mtval_q <= '0;
    else if (detect_en && trap_evt) mtval_q <= misalign_evt ? misalign_addr_i : '0;
  end
`endif

  assign stall_flag_o = (state_q != S_IDLE) | event_detect | int_assert_o;

endmodule

// File: tb/tb_clint_arb.sv
// Self-checking bench for clint_arb: directed vector table, hand-written corner
// sequences and randomized events against a rule-level reference model.
module tb_clint_arb;
  localparam int NCYC = 10;
  localparam logic [1:0] K_NONE = 2'd0, K_TRAP = 2'd1, K_MRET = 2'd2;
`ifdef CLINT_MTVAL_EN
  localparam bit MTVAL = 1'b1;
`else
  localparam bit MTVAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  irq_i, irq_mask_i, irq_ack_o;
  logic        inst_ecall_i, inst_ebreak_i, inst_mret_i, misalign_i;
  logic [31:0] inst_addr_i, misalign_addr_i, csr_mtvec, csr_mepc, csr_mstatus;
  logic        we_o, stall_flag_o, int_assert_o;
  logic [31:0] waddr_o, data_o, int_addr_o;

  clint_arb dut (
    .clk(clk), .rst_n(rst_n), .irq_i(irq_i), .irq_mask_i(irq_mask_i),
    .inst_ecall_i(inst_ecall_i), .inst_ebreak_i(inst_ebreak_i), .inst_mret_i(inst_mret_i),
    .misalign_i(misalign_i), .inst_addr_i(inst_addr_i), .misalign_addr_i(misalign_addr_i),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .csr_mstatus(csr_mstatus),
    .we_o(we_o), .waddr_o(waddr_o), .data_o(data_o), .stall_flag_o(stall_flag_o),
    .int_assert_o(int_assert_o), .int_addr_o(int_addr_o), .irq_ack_o(irq_ack_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  irq, mask;
    logic [31:0] mstatus, mtvec, mepc, pc, maddr;
    logic        ecall, ebreak, mret, misalign;
    logic [7:0]  late_irq;
    logic        keep_irq;
  } stim_t;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] mepc, mcause, mtval, mstatus, target;
    logic [7:0]  ack;
  } exp_t;

  typedef struct packed { stim_t s; exp_t e; } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: what the trap rules say should happen for a given stimulus.
  function automatic exp_t model(input stim_t s);
    exp_t e;
    logic [7:0] pend, low;
    int idx;
    e = '0;
    pend = s.irq & s.mask;
    e.mepc = s.pc;
    e.mstatus = (s.mstatus & ~32'h88) | (s.mstatus[3] ? 32'h80 : 32'h0);
    e.target = s.mtvec & ~32'h3;
    if (pend != 0 && s.mstatus[3]) begin
      low = pend & (~pend + 8'd1);
      idx = $clog2(low);
      e.kind = K_TRAP;
      e.mcause = 32'h8000_0000 | 32'(16 + idx);
      e.ack = low;
      if (s.mtvec[1:0] == 2'b01) e.target = e.target + 4 * (e.mcause & 32'hFF);
    end else if (s.ebreak) begin
      e.kind = K_TRAP; e.mcause = 32'd3;
    end else if (s.ecall) begin
      e.kind = K_TRAP; e.mcause = 32'd11;
    end else if (s.misalign) begin
      e.kind = K_TRAP; e.mcause = 32'd4; e.mtval = s.maddr;
    end else if (s.mret) begin
      e.kind = K_MRET;
      e.mstatus = (s.mstatus & ~32'h88) | 32'h80 | (s.mstatus[7] ? 32'h8 : 32'h0);
      e.target = s.mepc;
    end else begin
      e.kind = K_NONE;
    end
    return e;
  endfunction

  // Expected output tuple at cycle c (c=0 is the cycle the event is presented, before edge E0).
  function automatic logic [127:0] exp_at(input exp_t e, input int c);
    logic [31:0] wa[4], wd[4];
    int nw, redir;
    logic we, as, st;
    logic [31:0] a, d, ia;
    logic [7:0] ak;
    nw = 0;
    if (e.kind == K_TRAP) begin
      wa[0] = 32'h341; wd[0] = e.mepc;
      wa[1] = 32'h342; wd[1] = e.mcause;
      nw = 2;
      if (MTVAL) begin wa[nw] = 32'h343; wd[nw] = e.mtval; nw++; end
      wa[nw] = 32'h300; wd[nw] = e.mstatus; nw++;
    end else if (e.kind == K_MRET) begin
      wa[0] = 32'h300; wd[0] = e.mstatus; nw = 1;
    end
    redir = (e.kind == K_NONE) ? -1 : 1 + nw;
    we = (c >= 2) && (c < 2 + nw);
    a = 32'h0; d = 32'h0;
    if (we) begin a = wa[c-2]; d = wd[c-2]; end
    as = (c == redir);
    ia = as ? e.target : 32'h0;
    ak = as ? e.ack : 8'h0;
    st = (e.kind != K_NONE) && (c <= redir);
    return {21'b0, we, a, d, as, ia, ak, st};
  endfunction

  // Called just after a rising edge; returns just after a rising edge. Models the CSR file and ex redirect.
  task automatic run_case(input string tag, input stim_t s, input exp_t e);
    logic pw, sa;
    logic [31:0] pa, pd;
    irq_i = s.irq; irq_mask_i = s.mask; csr_mstatus = s.mstatus; csr_mtvec = s.mtvec;
    csr_mepc = s.mepc; inst_addr_i = s.pc; misalign_addr_i = s.maddr;
    inst_ecall_i = s.ecall; inst_ebreak_i = s.ebreak; inst_mret_i = s.mret; misalign_i = s.misalign;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      check($sformatf("%s c%0d", tag, c),
            {21'b0, we_o, waddr_o, data_o, int_assert_o, int_addr_o, irq_ack_o, stall_flag_o},
            exp_at(e, c));
      pw = we_o; pa = waddr_o; pd = data_o; sa = int_assert_o;
      @(posedge clk); #1;
      if (pw && pa == 32'h300) csr_mstatus = pd;
      if (pw && pa == 32'h341) csr_mepc = pd;
      if (c == 1 && s.late_irq != 8'h0) irq_i = s.late_irq;
      if (sa) begin
        inst_ecall_i = 1'b0; inst_ebreak_i = 1'b0; inst_mret_i = 1'b0; misalign_i = 1'b0;
        if (!s.keep_irq) irq_i = 8'h0;
      end
    end
  endtask

  vec_t  tbl[11];
  stim_t rs;
  int    nwe;

  initial begin
    //            irq    mask   mstatus       mtvec         mepc          pc            maddr         ec   eb   mr   ma   late   keep
    tbl[0]  = '{'{8'h0C, 8'hFF, 32'h0000_0008, 32'h0000_2000, 32'h0, 32'h0000_0100, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0},
                '{K_TRAP, 32'h100, 32'h8000_0012, 32'h0, 32'h80, 32'h2000, 8'h04}};
    tbl[1]  = '{'{8'h0C, 8'hFF, 32'h0000_0008, 32'h0000_2001, 32'h0, 32'h0000_0100, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0},
                '{K_TRAP, 32'h100, 32'h8000_0012, 32'h0, 32'h80, 32'h2048, 8'h04}};
    tbl[2]  = '{'{8'h01, 8'hFF, 32'h0000_0000, 32'h0000_2000, 32'h0, 32'h0000_0040, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0},
                '{K_TRAP, 32'h40, 32'd11, 32'h0, 32'h0, 32'h2000, 8'h00}};
    tbl[3]  = '{'{8'h00, 8'hFF, 32'h0000_0080, 32'h0000_2000, 32'h44, 32'h0000_0030, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0},
                '{K_MRET, 32'h0, 32'h0, 32'h0, 32'h88, 32'h44, 8'h00}};
    tbl[4]  = '{'{8'h00, 8'hFF, 32'h0000_0088, 32'h0000_3001, 32'h0, 32'h0000_0200, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0},
                '{K_TRAP, 32'h200, 32'd3, 32'h0, 32'h80, 32'h3000, 8'h00}};
    tbl[5]  = '{'{8'h00, 8'hFF, 32'h0000_1808, 32'h0000_4003, 32'h0, 32'h0000_0300, 32'h1003, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0},
                '{K_TRAP, 32'h300, 32'd4, 32'h1003, 32'h1880, 32'h4000, 8'h00}};
    tbl[6]  = '{'{8'h80, 8'h80, 32'h0000_0008, 32'h0000_1001, 32'h0, 32'h0000_0500, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0},
                '{K_TRAP, 32'h500, 32'h8000_0017, 32'h0, 32'h80, 32'h105C, 8'h80}};
    tbl[7]  = '{'{8'hFF, 8'hF0, 32'h0000_0008, 32'h0000_1001, 32'h0, 32'h0000_0600, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0},
                '{K_TRAP, 32'h600, 32'h8000_0014, 32'h0, 32'h80, 32'h1050, 8'h10}};
    tbl[8]  = '{'{8'hFF, 8'h00, 32'h0000_0008, 32'h0000_1000, 32'h0, 32'h0000_0700, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0},
                '{K_NONE, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 8'h00}};
    tbl[9]  = '{'{8'h01, 8'h01, 32'h0000_0000, 32'h0000_1000, 32'h88, 32'h0000_0800, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0},
                '{K_MRET, 32'h0, 32'h0, 32'h0, 32'h80, 32'h88, 8'h00}};
    // irq raised mid-ecall must be ignored, then masked by the cleared MIE afterwards
    tbl[10] = '{'{8'h00, 8'hFF, 32'h0000_0008, 32'h0000_2000, 32'h0, 32'h0000_0040, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1},
                '{K_TRAP, 32'h40, 32'd11, 32'h0, 32'h80, 32'h2000, 8'h00}};

    rst_n = 1'b0;
    irq_i = 8'h0; irq_mask_i = 8'h0; inst_ecall_i = 1'b0; inst_ebreak_i = 1'b0;
    inst_mret_i = 1'b0; misalign_i = 1'b0; inst_addr_i = 32'h0; misalign_addr_i = 32'h0;
    csr_mtvec = 32'h0; csr_mepc = 32'h0; csr_mstatus = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_state", {21'b0, we_o, waddr_o, data_o, int_assert_o, int_addr_o, irq_ack_o, stall_flag_o}, 128'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run_case($sformatf("vec%0d", i), tbl[i].s, tbl[i].e);

    // Reset asserted while in MCAUSE aborts the sequence with no further writes.
    irq_i = 8'h0; irq_mask_i = 8'hFF; csr_mstatus = 32'h8; csr_mtvec = 32'h2000;
    inst_addr_i = 32'h60; inst_ecall_i = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    check("mid_mepc_write", {96'b0, we_o, waddr_o}, {96'b0, 1'b1, 32'h341});
    rst_n = 1'b0; #1;
    check("rst_async", {32'b0, we_o, waddr_o, data_o, int_assert_o, int_addr_o, irq_ack_o},
          {32'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 8'h0});
    inst_ecall_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    nwe = 0;
    repeat (6) begin
      @(negedge clk);
      if (we_o || int_assert_o) nwe++;
    end
    check("rst_no_writes", 128'(nwe), 128'h0);
    check("rst_idle_stall", {127'b0, stall_flag_o}, 128'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      rs.irq = 8'($urandom);
      rs.mask = 8'($urandom);
      rs.mstatus = $urandom;
      rs.mtvec = $urandom;
      rs.mepc = $urandom;
      rs.pc = $urandom;
      rs.maddr = $urandom;
      rs.ecall = ($urandom_range(0, 3) == 0);
      rs.ebreak = ($urandom_range(0, 3) == 0);
      rs.mret = ($urandom_range(0, 2) == 0);
      rs.misalign = ($urandom_range(0, 3) == 0);
      rs.late_irq = 8'h0;
      rs.keep_irq = 1'b0;
      run_case($sformatf("rnd%0d", i), rs, model(rs));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
